// File: rtl/scope_pkg.sv
// Shared types and constants for the waveform capture path and the display draw path.
// Contents: capture state encoding, trigger mode encoding, default buffer geometry.
package scope_pkg;

    localparam int unsigned ScopeDepth = 1280;  // one sample per horizontal pixel
    localparam int unsigned ScopeAw    = 11;    // covers ScopeDepth-1
    localparam int unsigned ScopeDw    = 10;    // audio sample width

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPrefill = 3'd1,
        StArmed   = 3'd2,
        StCapture = 3'd3,
        StHold    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ModeAuto   = 2'd0,
        ModeNormal = 2'd1,
        ModeSingle = 2'd2,
        ModeFree   = 2'd3
    } mode_e;

endpackage

// File: rtl/trig_detect.sv
// Rising-edge trigger detector with auto-mode timeout.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   sample_valid_i   qualifies sample_i
//   sample_i         current sample
//   trig_level_i     rising-edge threshold
//   armed_i          detection enabled (controller is ARMED and not free-running)
//   auto_en_i        force a trigger after AUTO_TIMEOUT armed samples
//   trig_hit_o       trigger on the current valid sample
module trig_detect #(
    parameter int unsigned DW           = 10,
    parameter int unsigned AUTO_TIMEOUT = 4000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sample_valid_i,
    input  logic [DW-1:0] sample_i,
    input  logic [DW-1:0] trig_level_i,
    input  logic          armed_i,
    input  logic          auto_en_i,
    output logic          trig_hit_o
);

    localparam int unsigned TW = $clog2(AUTO_TIMEOUT + 1);

    logic [DW-1:0] prev_q, prev_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          edge_hit, tmo_hit;

    always_comb begin
        edge_hit   = (prev_q < trig_level_i) && (sample_i >= trig_level_i);
        // Counter holds the number of armed samples already seen, so the
        // AUTO_TIMEOUT-th armed sample is the one that gets forced.
        tmo_hit    = auto_en_i && (tmo_q == TW'(AUTO_TIMEOUT - 1));
        trig_hit_o = armed_i && sample_valid_i && (edge_hit || tmo_hit);

        prev_d = sample_valid_i ? sample_i : prev_q;

        tmo_d = tmo_q;
        if (!armed_i || trig_hit_o) begin
            tmo_d = '0;
        end else if (sample_valid_i) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '1;  // all-ones: nothing can be "below" it, so no false first edge
            tmo_q  <= '0;
        end else begin
            prev_q <= prev_d;
            tmo_q  <= tmo_d;
        end
    end

endmodule

// File: rtl/waveform_capture_ctrl.sv
// Triggered capture controller for the waveform display buffer.
// Sequences pre-trigger fill, trigger detection, post-trigger capture and display hold,
// producing buffer write strobes and the trigger-aligned frame start pointer.
// Ports:
//   clk_sample, reset           sole clock, synchronous active-high reset
//   sample_valid, sample_in     incoming audio samples
//   trig_level, mode, rearm     trigger threshold, trigger mode, single-shot rearm
//   wr_en, wr_addr, wr_data     buffer write port (registered, 1 cycle latency)
//   frame_start, frame_valid    leftmost displayed sample, frozen-frame flag
//   triggered, state_o          trigger pulse, debug state
module waveform_capture_ctrl
    import scope_pkg::*;
#(
    parameter int unsigned DEPTH        = ScopeDepth,
    parameter int unsigned AW           = ScopeAw,
    parameter int unsigned DW           = ScopeDw,
    parameter int unsigned PRE          = 320,
    parameter int unsigned AUTO_TIMEOUT = 4000,
    parameter int unsigned HOLD_SAMPLES = 2000
) (
    input  logic          clk_sample,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_in,
    input  logic [DW-1:0] trig_level,
    input  logic [1:0]    mode,
    input  logic          rearm,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] frame_start,
    output logic          frame_valid,
    output logic          triggered,
    output logic [2:0]    state_o
);

    localparam int unsigned CntMax   = (DEPTH > HOLD_SAMPLES) ? DEPTH : HOLD_SAMPLES;
    localparam int unsigned CntW     = $clog2(CntMax + 1);
    localparam logic [AW:0] DepthExt = (AW + 1)'(DEPTH);

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    function automatic logic [AW-1:0] addr_sub(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[AW]) begin
            diff = diff + DepthExt;
        end
        return diff[AW-1:0];
    endfunction

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;  // PREFILL, CAPTURE and HOLD progress share one counter
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [AW-1:0] frame_start_q, frame_start_d;
    logic          frame_valid_q, frame_valid_d;
    logic          triggered_q, triggered_d;
    logic          do_write, enter_pre, trig_hit;

    trig_detect #(
        .DW           (DW),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) u_trig_detect (
        .clk_i          (clk_sample),
        .rst_i          (reset),
        .sample_valid_i (sample_valid),
        .sample_i       (sample_in),
        .trig_level_i   (trig_level),
        .armed_i        ((state_q == StArmed) && (mode_q != ModeFree)),
        .auto_en_i      (mode_q == ModeAuto),
        .trig_hit_o     (trig_hit)
    );

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_start_d = frame_start_q;
        frame_valid_d = frame_valid_q;
        triggered_d   = 1'b0;
        do_write      = 1'b0;
        enter_pre     = 1'b0;

        unique case (state_q)
            StIdle: enter_pre = 1'b1;
            StPrefill: begin
                if (sample_valid) begin
                    do_write = 1'b1;
                    if (cnt_q == CntW'(PRE - 1)) begin
                        state_d = StArmed;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StArmed: begin
                if (sample_valid) begin
                    do_write = 1'b1;
                    if (mode_q == ModeFree) begin
                        frame_start_d = addr_inc(ptr_q);
                    end else if (trig_hit) begin
                        frame_start_d = addr_sub(ptr_q, AW'(PRE));
                        triggered_d   = 1'b1;
                        state_d       = StCapture;
                        cnt_d         = '0;
                    end
                end
            end
            StCapture: begin
                if (sample_valid) begin
                    do_write = 1'b1;
                    if (cnt_q == CntW'(DEPTH - PRE - 2)) begin
                        state_d       = StHold;
                        frame_valid_d = 1'b1;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StHold: begin
                if (sample_valid) begin
                    if (mode_q == ModeSingle) begin
                        enter_pre = rearm;
                    end else if (cnt_q == CntW'(HOLD_SAMPLES - 1)) begin
                        enter_pre = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = sample_in;
            ptr_d     = addr_inc(ptr_q);
        end

        // Every PREFILL entry restarts the buffer at address 0 and latches the mode.
        if (enter_pre) begin
            state_d       = StPrefill;
            mode_d        = mode_e'(mode);
            ptr_d         = '0;
            cnt_d         = '0;
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sample) begin
        if (reset) begin
            state_q       <= StIdle;
            mode_q        <= ModeAuto;
            ptr_q         <= '0;
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_start_q <= '0;
            frame_valid_q <= 1'b0;
            triggered_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_start_q <= frame_start_d;
            frame_valid_q <= frame_valid_d;
            triggered_q   <= triggered_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_start = frame_start_q;
    assign frame_valid = frame_valid_q;
    assign triggered   = triggered_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_waveform_capture_ctrl.sv
// Self-checking bench for waveform_capture_ctrl. Expected frames come from a
// sample-stream model: write k goes to address k mod DEPTH, the trigger is the
// first qualifying sample at stream index >= PRE, and the frame ends DEPTH-PRE-1
// writes after it.
module tb_waveform_capture_ctrl;
    import scope_pkg::*;

    localparam int DEPTH = 1280, AW = 11, DW = 10, PRE = 320;
    localparam int AUTO_TIMEOUT = 4000, HOLD_SAMPLES = 2000;

    logic          clk_sample = 1'b0;
    logic          reset = 1'b1, sample_valid = 1'b0, rearm = 1'b0;
    logic [DW-1:0] sample_in = '0, trig_level = '0;
    logic [1:0]    mode = 2'd1;
    logic          wr_en, frame_valid, triggered;
    logic [AW-1:0] wr_addr, frame_start;
    logic [DW-1:0] wr_data;
    logic [2:0]    state_o;

    int checks = 0, errors = 0;
    int stim[$];
    int o_addr[$], o_data[$], o_fs[$], o_cyc[$], o_state[$];
    bit o_trig[$], o_fv[$];
    int trig_total, addr_oob;

    waveform_capture_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .PRE(PRE),
        .AUTO_TIMEOUT(AUTO_TIMEOUT), .HOLD_SAMPLES(HOLD_SAMPLES)
    ) dut (
        .clk_sample(clk_sample), .reset(reset), .sample_valid(sample_valid),
        .sample_in(sample_in), .trig_level(trig_level), .mode(mode), .rearm(rearm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_start(frame_start),
        .frame_valid(frame_valid), .triggered(triggered), .state_o(state_o)
    );

    always #5 clk_sample = ~clk_sample;

    // Reference trigger point over the current stream.
    function automatic int model_trigger(input bit auto_m, input int lvl);
        for (int i = PRE; i < stim.size(); i++) begin
            if (stim[i-1] < lvl && stim[i] >= lvl) return i;
            if (auto_m && (i - PRE) == AUTO_TIMEOUT - 1) return i;
        end
        return -1;
    endfunction

    // Number of discrepancies between the recorded writes and the expected frame.
    function automatic int frame_errs(input int t, input int n);
        int e = 0;
        int es;
        if (o_addr.size() != n) return 1000000 + o_addr.size();
        for (int i = 0; i < n; i++) begin
            if (o_addr[i] != i % DEPTH) e++;
            if (o_data[i] != stim[i]) e++;
            if (o_trig[i] != (i == t)) e++;
            if (i == t && o_fs[i] != (t - PRE) % DEPTH) e++;
            if (o_fv[i] != (i == n - 1)) e++;
            es = (i < PRE - 1) ? int'(StPrefill) : (i < t) ? int'(StArmed) :
                 (i < n - 1) ? int'(StCapture) : int'(StHold);
            if (o_state[i] != es) e++;
        end
        if (trig_total != 1) e++;
        return e + addr_oob;
    endfunction

    task automatic observe(input int cyc);
        if (triggered === 1'b1) trig_total++;
        if (wr_en === 1'b1) begin
            if (int'(wr_addr) >= DEPTH) addr_oob++;
            o_addr.push_back(int'(wr_addr));
            o_data.push_back(int'(wr_data));
            o_fs.push_back(int'(frame_start));
            o_state.push_back(int'(state_o));
            o_cyc.push_back(cyc);
            o_trig.push_back(triggered);
            o_fv.push_back(frame_valid);
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clk_sample);
        reset = 1'b1; sample_valid = 1'b0; rearm = 1'b0; mode = m;
        @(negedge clk_sample);
        reset = 1'b0;
        @(negedge clk_sample);
    endtask

    // Feeds n stream samples; a sample driven at cycle c is observed with tag c+1.
    task automatic drive_stream(input int n, input int vmode);
        int k = 0, cyc = 0;
        bit v;
        o_addr.delete(); o_data.delete(); o_fs.delete(); o_cyc.delete();
        o_state.delete(); o_trig.delete(); o_fv.delete();
        trig_total = 0; addr_oob = 0;
        while (k < n) begin
            @(negedge clk_sample);
            observe(cyc);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            sample_valid = v;
            if (v) begin
                sample_in = DW'(stim[k]);
                k++;
            end else begin
                sample_in = DW'($urandom);
            end
            cyc++;
        end
        @(negedge clk_sample);
        observe(cyc);
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_sample);
        reset = 1'b1; sample_valid = 1'b1; sample_in = 10'd700;
        repeat (2) @(negedge clk_sample);
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_start, frame_valid, triggered, state_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%0d fs=%0d fv=%b trig=%b st=%0d, want all 0",
                     wr_en, wr_addr, wr_data, frame_start, frame_valid, triggered, state_o);
        end
        reset = 1'b0; sample_valid = 1'b0;
        @(negedge clk_sample);
        checks++;
        if (state_o !== 3'(StPrefill)) begin
            errors++;
            $display("FAIL reset_to_prefill: state %0d, want %0d", state_o, StPrefill);
        end
    endtask

    task automatic test_normal_ramp();
        int t, n, e, bad;
        do_reset(2'(ModeNormal));
        trig_level = 10'd512;
        stim.delete();
        for (int i = 0; i < 3000; i++) stim.push_back(i % 1024);
        t = model_trigger(1'b0, 512);
        n = t + DEPTH - PRE;
        drive_stream(n, 0);
        e = frame_errs(t, n);
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL ramp_frame: %0d discrepancies (writes %0d), want 0", e, o_addr.size());
        end
        checks++;
        if (o_cyc.size() <= t || o_cyc[t] !== t + 1) begin
            errors++;
            $display("FAIL ramp_trigger_cycle: got %0d want %0d", o_cyc.size() > t ? o_cyc[t] : -1, t + 1);
        end
        // HOLD: rearm must be ignored outside single mode; release after HOLD_SAMPLES valid cycles.
        bad = 0;
        for (int c = 0; c < HOLD_SAMPLES; c++) begin
            @(negedge clk_sample);
            if (wr_en !== 1'b0 || frame_valid !== 1'b1 || state_o !== 3'(StHold)) bad++;
            sample_valid = 1'b1; sample_in = DW'($urandom); rearm = (c < 10);
        end
        @(negedge clk_sample);
        sample_valid = 1'b0; rearm = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ramp_hold_stable: %0d bad hold cycles, want 0", bad);
        end
        checks++;
        if (state_o !== 3'(StPrefill) || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL ramp_hold_release: state %0d fv %b, want %0d fv 0", state_o, frame_valid, StPrefill);
        end
    endtask

    task automatic test_auto_timeout(input int vmode, input string name);
        int t, n, e, want_cyc;
        do_reset(2'(ModeAuto));
        trig_level = 10'd512;
        stim.delete();
        for (int i = 0; i < PRE + AUTO_TIMEOUT + DEPTH; i++) stim.push_back(100);
        t = model_trigger(1'b1, 512);
        n = t + DEPTH - PRE;
        drive_stream(n, vmode);
        e = frame_errs(t, n);
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL %s_frame: %0d discrepancies, want 0", name, e);
        end
        want_cyc = (vmode == 1) ? 2 * t + 1 : t + 1;
        checks++;
        if (o_cyc.size() <= t || o_cyc[t] !== want_cyc) begin
            errors++;
            $display("FAIL %s_trigger_cycle: got %0d want %0d", name, o_cyc.size() > t ? o_cyc[t] : -1, want_cyc);
        end
    endtask

    task automatic test_normal_no_trigger();
        int bad = 0;
        do_reset(2'(ModeNormal));
        trig_level = 10'd512;
        stim.delete();
        for (int i = 0; i < 6000; i++) stim.push_back(100);
        drive_stream(6000, 0);
        for (int i = 0; i < o_addr.size(); i++) begin
            if (o_addr[i] != i % DEPTH || o_fv[i]) bad++;
            if (i >= PRE - 1 && o_state[i] != int'(StArmed)) bad++;
        end
        checks++;
        if (o_addr.size() !== 6000 || trig_total !== 0 || bad !== 0) begin
            errors++;
            $display("FAIL normal_stays_armed: writes %0d trig %0d bad %0d, want 6000 0 0",
                     o_addr.size(), trig_total, bad);
        end
    endtask

    task automatic test_single_rearm();
        int t, n, e, bad = 0;
        do_reset(2'(ModeSingle));
        trig_level = 10'd512;
        stim.delete();
        for (int i = 0; i < 2000; i++) stim.push_back(int'($urandom_range(0, 1023)));
        stim[PRE + 60] = 0; stim[PRE + 61] = 1023;
        t = model_trigger(1'b0, 512);
        n = t + DEPTH - PRE;
        drive_stream(n, 2);
        e = frame_errs(t, n);
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL single_frame: %0d discrepancies, want 0", e);
        end
        mode = 2'(ModeAuto);  // must not matter until the next PREFILL
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk_sample);
            if (wr_en !== 1'b0 || frame_valid !== 1'b1 || state_o !== 3'(StHold)) bad++;
            sample_valid = 1'b1; sample_in = DW'($urandom);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL single_hold: %0d bad cycles of 10000, want 0", bad);
        end
        @(negedge clk_sample);
        rearm = 1'b1;
        @(negedge clk_sample);
        rearm = 1'b0; sample_valid = 1'b0;
        checks++;
        if (state_o !== 3'(StPrefill) || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_rearm: state %0d fv %b, want %0d fv 0", state_o, frame_valid, StPrefill);
        end
    endtask

    task automatic test_wrap_trigger();
        int t, n, e;
        do_reset(2'(ModeNormal));
        trig_level = 10'd512;
        stim.delete();
        for (int i = 0; i < 1380; i++) stim.push_back(0);
        for (int i = 0; i < 1000; i++) stim.push_back(600);
        t = model_trigger(1'b0, 512);
        n = t + DEPTH - PRE;
        drive_stream(n, 0);
        e = frame_errs(t, n);
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL wrap_frame: %0d discrepancies, want 0", e);
        end
        checks++;
        if (o_fs.size() <= t || o_fs[t] !== 1060 || o_addr[t] !== 100) begin
            errors++;
            $display("FAIL wrap_frame_start: got %0d want 1060", o_fs.size() > t ? o_fs[t] : -1);
        end
    endtask

    task automatic test_prefill_edge();
        int t, n, e;
        do_reset(2'(ModeNormal));
        trig_level = 10'd512;
        stim.delete();
        for (int i = 0; i < 2000; i++) stim.push_back((i < PRE - 1 || i == 500) ? 0 : 600);
        t = model_trigger(1'b0, 512);
        n = t + DEPTH - PRE;
        drive_stream(n, 0);
        e = frame_errs(t, n);
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL prefill_edge_ignored: %0d discrepancies, want 0", e);
        end
    endtask

    task automatic test_free_run();
        int bad = 0;
        do_reset(2'(ModeFree));
        trig_level = 10'd512;
        stim.delete();
        for (int i = 0; i < 3000; i++) stim.push_back((i % 7 == 0) ? 0 : int'($urandom_range(0, 1023)));
        drive_stream(3000, 2);
        for (int i = 0; i < o_addr.size(); i++) begin
            if (o_addr[i] != i % DEPTH || o_data[i] != stim[i] || o_fv[i]) bad++;
            if (i >= PRE && o_fs[i] != (i + 1) % DEPTH) bad++;
            if (i >= PRE - 1 && o_state[i] != int'(StArmed)) bad++;
        end
        checks++;
        if (o_addr.size() !== 3000 || trig_total !== 0 || bad !== 0 || addr_oob !== 0) begin
            errors++;
            $display("FAIL free_run: writes %0d trig %0d bad %0d, want 3000 0 0",
                     o_addr.size(), trig_total, bad);
        end
    endtask

    task automatic test_reset_mid_capture();
        int bad = 0;
        do_reset(2'(ModeNormal));
        trig_level = 10'd512;
        stim.delete();
        for (int i = 0; i < 1200; i++) stim.push_back(i % 1024);
        drive_stream(612, 0);
        @(negedge clk_sample);
        reset = 1'b1; sample_valid = 1'b1; sample_in = 10'd5;
        @(negedge clk_sample);
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_start, frame_valid, triggered, state_o} !== '0) begin
            errors++;
            $display("FAIL midcap_reset: got wr_en=%b addr=%0d fs=%0d fv=%b st=%0d, want all 0",
                     wr_en, wr_addr, frame_start, frame_valid, state_o);
        end
        reset = 1'b0; sample_valid = 1'b0;
        @(negedge clk_sample);
        drive_stream(5, 0);
        for (int i = 0; i < o_addr.size(); i++) if (o_addr[i] != i || o_data[i] != stim[i]) bad++;
        checks++;
        if (o_addr.size() !== 5 || bad !== 0) begin
            errors++;
            $display("FAIL midcap_restart: writes %0d bad %0d first addr %0d, want 5 0 0",
                     o_addr.size(), bad, o_addr.size() > 0 ? o_addr[0] : -1);
        end
    endtask

    task automatic test_random();
        int t, n, e, m, lvl, pos;
        for (int it = 0; it < 2; it++) begin
            m   = $urandom_range(0, 2);
            lvl = $urandom_range(100, 900);
            do_reset(2'(m));
            trig_level = DW'(lvl);
            stim.delete();
            for (int i = 0; i < PRE + AUTO_TIMEOUT + DEPTH; i++) stim.push_back(int'($urandom_range(0, 1023)));
            pos = $urandom_range(PRE + 1, PRE + 3000);
            stim[pos - 1] = 0; stim[pos] = 1023;
            t = model_trigger(m == 0, lvl);
            n = t + DEPTH - PRE;
            drive_stream(n, 2);
            e = frame_errs(t, n);
            checks++;
            if (e !== 0) begin
                errors++;
                $display("FAIL random_frame[%0d]: mode %0d lvl %0d, %0d discrepancies, want 0", it, m, lvl, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_ramp();
        test_auto_timeout(0, "auto_full");
        test_auto_timeout(1, "auto_half");
        test_normal_no_trigger();
        test_single_rearm();
        test_wrap_trigger();
        test_prefill_edge();
        test_free_run();
        test_reset_mid_capture();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

endmodule
